// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants and types for the memory bus arbiter slice.
//   ARB_STATE_W : width of the debug state output
//   arb_state_t : FSM state encoding (IDLE/GNT_CPU/GNT_DMA/DONE)
//   owner_e     : which requester owns the current access
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ARB_STATE_W = 2;

  typedef logic [ARB_STATE_W-1:0] arb_state_t;

  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t GNT_CPU = 2'd1;
  localparam arb_state_t GNT_DMA = 2'd2;
  localparam arb_state_t DONE    = 2'd3;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// ---------------------------------------------------------------------------
// mem_arb_lat_cnt
// Loadable down-counter that times the grant phase of one memory access.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : load MEM_LAT-1 (first grant cycle follows)
//   dec        : count down by one while above zero
//   last       : counter is zero, i.e. this is the last grant cycle
// ---------------------------------------------------------------------------
module mem_arb_lat_cnt #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares a single-port memory between the multicycle CPU memory interface
// and a read-only DMA requester (display refresh fetcher). One access at a
// time: IDLE -> GNT_x for MEM_LAT cycles -> DONE (ready/ack pulse) -> IDLE.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU request (level) and access attributes
//   cpu_rdata, cpu_ready     : registered CPU read data, completion pulse
//   dma_req/addr             : DMA read request (level) and address
//   dma_rdata, dma_ack       : registered DMA read data, completion pulse
//   mem_en/we/addr/wdata     : memory port drive
//   mem_rdata                : memory read data, valid on last grant cycle
//   arb_state                : current FSM state for debug
// Build option:
//   MEM_ARB_FAIR_EN : when defined, a starvation counter forces a CPU grant
//                     after MAX_BURST DMA grants made while the CPU waits.
//                     Otherwise arbitration is strict DMA-first.
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ready,
  input  logic                   dma_req,
  input  logic [ADDR_W-1:0]      dma_addr,
  output logic [DATA_W-1:0]      dma_rdata,
  output logic                   dma_ack,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [ARB_STATE_W-1:0] arb_state
);

  if (MEM_LAT < 1 || MAX_BURST < 1) begin : g_bad_param
    $error("mem_bus_arbiter: MEM_LAT and MAX_BURST must be >= 1");
  end

  arb_state_t        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic in_grant;
  logic cnt_load;
  logic cnt_last;
  logic cpu_forced;
  logic pick_dma;

  assign in_grant = (state_q == GNT_CPU) || (state_q == GNT_DMA);

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_BURST + 1);

  logic [SW-1:0] starv_q, starv_d;

  assign cpu_forced = (starv_q == SW'(MAX_BURST));

  // Count DMA wins while the CPU is waiting; any CPU grant or an idle
  // cycle without a CPU request means the CPU is no longer starved.
  always_comb begin
    starv_d = starv_q;
    if (state_q == IDLE) begin
      if (!cpu_req) begin
        starv_d = '0;
      end else if (pick_dma) begin
        starv_d = starv_q + 1'b1;
      end else begin
        starv_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starv_q <= '0;
    end else begin
      starv_q <= starv_d;
    end
  end
`else
  assign cpu_forced = 1'b0;
`endif

  // DMA wins unless the CPU is waiting and has been starved long enough.
  assign pick_dma = dma_req && !(cpu_req && cpu_forced);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    first_d     = first_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cnt_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_dma) begin
          state_d  = GNT_DMA;
          owner_d  = OWN_DMA;
          addr_d   = dma_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
          first_d  = 1'b1;
          cnt_load = 1'b1;
        end else if (cpu_req) begin
          state_d  = GNT_CPU;
          owner_d  = OWN_CPU;
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          we_d     = cpu_we;
          first_d  = 1'b1;
          cnt_load = 1'b1;
        end
      end
      GNT_CPU, GNT_DMA: begin
        first_d = 1'b0;
        if (cnt_last) begin
          state_d = DONE;
          if (owner_q == OWN_DMA) begin
            dma_rdata_d = mem_rdata;
          end else if (!we_q) begin
            cpu_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      first_q     <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      first_q     <= first_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  mem_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (in_grant),
    .last  (cnt_last)
  );

  // Every output is a register or a decode of registered state only.
  assign mem_en    = in_grant;
  assign mem_we    = (state_q == GNT_CPU) && we_q && first_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ready = (state_q == DONE) && (owner_q == OWN_CPU);
  assign dma_ack   = (state_q == DONE) && (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign arb_state = state_q;

endmodule
